// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM port arbiter: FSM state encoding and the
// controller data width.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } arb_state_e;

  localparam int MEM_DATA_W = 8;

endpackage

// File: rtl/sdram_rr_picker.sv
// Combinational round-robin select: first requesting port at or above rr_ptr,
// wrapping at NUM_PORTS. The pointer register lives in the parent.
module sdram_rr_picker #(
  parameter  int NUM_PORTS = 4,
  localparam int PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_W-1:0]    rr_ptr,
  output logic                 grant_valid,
  output logic [PORT_W-1:0]    grant_idx,
  output logic [NUM_PORTS-1:0] grant_onehot
);

  // Scan offsets from farthest to nearest so the nearest hit is assigned last
  // and wins, with no early exit needed.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      int s;
      s = int'(rr_ptr) + i;
      if (s >= NUM_PORTS) s = s - NUM_PORTS;
      if (req[PORT_W'(s)]) begin
        grant_valid = 1'b1;
        grant_idx   = PORT_W'(s);
      end
    end
    grant_onehot = grant_valid ? (NUM_PORTS'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one byte-wide SDRAM controller command port
// between NUM_PORTS requesters; routes read data back to the owning port.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter  int NUM_PORTS  = 4,
  parameter  int ADDR_DEPTH = 25,
  localparam int PORT_W     = $clog2(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            req_valid,
  input  logic [NUM_PORTS-1:0]            req_wr,
  input  logic [NUM_PORTS*ADDR_DEPTH-1:0] req_addr,
  input  logic [NUM_PORTS*8-1:0]          req_wdata,
  output logic [NUM_PORTS-1:0]            req_ack,
  output logic [NUM_PORTS-1:0]            rsp_valid,
  output logic [MEM_DATA_W-1:0]           rsp_data,
  output logic                            mem_rd,
  output logic                            mem_wr,
  output logic [ADDR_DEPTH-1:0]           mem_addr,
  output logic [MEM_DATA_W-1:0]           mem_wdata,
  input  logic                            mem_rdy,
  input  logic                            mem_val,
  input  logic [MEM_DATA_W-1:0]           mem_rdata,
  output logic                            busy,
  output logic                            proto_err
);

  arb_state_e                                 state;
  logic [PORT_W-1:0]                          rr_ptr;
  logic [PORT_W-1:0]                          owner;
  logic [NUM_PORTS-1:0][ADDR_DEPTH-1:0]       addr_arr;
  logic [NUM_PORTS-1:0][MEM_DATA_W-1:0]       wdata_arr;
  logic                                       grant_valid;
  logic [PORT_W-1:0]                          grant_idx;
  logic [NUM_PORTS-1:0]                       grant_onehot;

  assign addr_arr  = req_addr;
  assign wdata_arr = req_wdata;

  sdram_rr_picker #(.NUM_PORTS(NUM_PORTS)) u_picker (
    .req          (req_valid),
    .rr_ptr       (rr_ptr),
    .grant_valid  (grant_valid),
    .grant_idx    (grant_idx),
    .grant_onehot (grant_onehot)
  );

  // Ack is the IDLE-state decode of the picker; masked in reset so no grant
  // is signalled for a capture that will not happen.
  assign req_ack = (state == IDLE && !rst) ? grant_onehot : '0;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      proto_err <= 1'b0;
    end else begin
      rsp_valid <= '0;
      if (mem_val && state != WAIT_RD) proto_err <= 1'b1;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner     <= grant_idx;
            mem_addr  <= addr_arr[grant_idx];
            mem_wdata <= wdata_arr[grant_idx];
            mem_wr    <= req_wr[grant_idx];
            mem_rd    <= ~req_wr[grant_idx];
            rr_ptr    <= (grant_idx == PORT_W'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          // Stalls indefinitely while the controller is refreshing or busy.
          if (mem_rdy) begin
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            state  <= mem_rd ? WAIT_RD : IDLE;
          end
        end
        WAIT_RD: begin
          if (mem_val) begin
            rsp_valid <= NUM_PORTS'(1) << owner;
            rsp_data  <= mem_rdata;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: table of transactions plus
// hand-written reset/protocol sequences, with an ack/response scoreboard.
module tb_sdram_port_arbiter;

  localparam int NP = 4;
  localparam int AD = 25;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     req_valid, req_wr;
  logic [NP*AD-1:0]  req_addr;
  logic [NP*8-1:0]   req_wdata;
  logic [NP-1:0]     req_ack, rsp_valid;
  logic [7:0]        rsp_data;
  logic              mem_rd, mem_wr;
  logic [AD-1:0]     mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_rdy, mem_val;
  logic [7:0]        mem_rdata;
  logic              busy, proto_err;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [NP-1:0] mask;
    bit            wr;
    logic [AD-1:0] addr;
    logic [7:0]    wdata;
    int            stall;
    int            lat;
    logic [7:0]    rdata;
    int            exp_p;
  } vec_t;

  typedef struct {
    int         port;
    logic [7:0] data;
  } rsp_t;

  int   exp_ack[$];
  rsp_t exp_rsp[$];
  vec_t tbl[11];
  int   mon_p;
  rsp_t mon_r;

  sdram_port_arbiter #(.NUM_PORTS(NP), .ADDR_DEPTH(AD)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdy(mem_rdy), .mem_val(mem_val), .mem_rdata(mem_rdata),
    .busy(busy), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NP-1:0] oh(input int p);
    return NP'(1) << p;
  endfunction

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Scoreboard: every ack and every response must match the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rd_wr_excl", 32'(mem_rd & mem_wr), 32'd0);
      if (req_ack != '0) begin
        if (exp_ack.size() == 0) chk("ack_unexpected", 32'(req_ack), 32'd0);
        else begin
          mon_p = exp_ack.pop_front();
          chk("ack_port", 32'(req_ack), 32'(oh(mon_p)));
        end
      end
      if (rsp_valid != '0) begin
        if (exp_rsp.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        else begin
          mon_r = exp_rsp.pop_front();
          chk("rsp_port", 32'(rsp_valid), 32'(oh(mon_r.port)));
          chk("rsp_byte", 32'(rsp_data), 32'(mon_r.data));
        end
      end
    end
  end

  task automatic txn(input vec_t v);
    rsp_t r;
    for (int p = 0; p < NP; p++) begin
      req_addr[p*AD +: AD] = (p == v.exp_p) ? v.addr : ~v.addr;
      req_wdata[p*8 +: 8]  = (p == v.exp_p) ? v.wdata : ~v.wdata;
    end
    req_wr    = {NP{v.wr}};
    req_valid = v.mask;
    mem_rdy   = 1'b0;
    exp_ack.push_back(v.exp_p);
    tick;
    req_valid = '0;
    for (int k = 0; k <= v.stall; k++) begin
      mem_rdy = (k == v.stall);
      chk("cmd_rd", 32'(mem_rd), 32'(!v.wr));
      chk("cmd_wr", 32'(mem_wr), 32'(v.wr));
      chk("cmd_addr", 32'(mem_addr), 32'(v.addr));
      chk("cmd_wdata", 32'(mem_wdata), 32'(v.wdata));
      chk("busy_issue", 32'(busy), 32'd1);
      tick;
    end
    mem_rdy = 1'b0;
    if (v.wr) begin
      chk("wr_done_idle", 32'(busy), 32'd0);
      chk("wr_done_cmd", 32'({mem_rd, mem_wr}), 32'd0);
      chk("wr_no_rsp", 32'(rsp_valid), 32'd0);
    end else begin
      chk("rd_cmd_drop", 32'(mem_rd), 32'd0);
      chk("busy_wait", 32'(busy), 32'd1);
      repeat (v.lat - 1) tick;
      mem_val   = 1'b1;
      mem_rdata = v.rdata;
      r.port = v.exp_p;
      r.data = v.rdata;
      exp_rsp.push_back(r);
      tick;
      mem_val = 1'b0;
      chk("rsp_valid", 32'(rsp_valid), 32'(oh(v.exp_p)));
      chk("rsp_data", 32'(rsp_data), 32'(v.rdata));
      chk("rd_done_idle", 32'(busy), 32'd0);
      tick;
      chk("rsp_pulse_end", 32'(rsp_valid), 32'd0);
      chk("rsp_data_hold", 32'(rsp_data), 32'(v.rdata));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"}, 32'(req_ack), 32'd0);
    chk({tag, "_rspv"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rspd"}, 32'(rsp_data), 32'd0);
    chk({tag, "_cmd"}, 32'({mem_rd, mem_wr}), 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_perr"}, 32'(proto_err), 32'd0);
  endtask

  initial begin
    int cyc;
    rsp_t dummy;
    //            mask     wr    addr          wdata  stall lat rdata  exp
    tbl[0]  = '{4'b0100, 1'b0, 25'h0001234, 8'h00, 0, 4, 8'hA5, 2};
    tbl[1]  = '{4'b0001, 1'b1, 25'h1FFFFFF, 8'h3C, 5, 0, 8'h00, 0};
    tbl[2]  = '{4'b0010, 1'b1, 25'h0000010, 8'h11, 0, 0, 8'h00, 1};
    tbl[3]  = '{4'b1010, 1'b1, 25'h0000020, 8'h22, 0, 0, 8'h00, 3};
    tbl[4]  = '{4'b1010, 1'b0, 25'h0000030, 8'h00, 0, 2, 8'h5A, 1};
    tbl[5]  = '{4'b0111, 1'b1, 25'h0ABCDEF, 8'h77, 0, 0, 8'h00, 2};
    tbl[6]  = '{4'b0111, 1'b0, 25'h0000001, 8'h00, 0, 1, 8'hC3, 0};
    tbl[7]  = '{4'b1111, 1'b1, 25'h1555555, 8'hE1, 0, 0, 8'h00, 1};
    tbl[8]  = '{4'b1001, 1'b0, 25'h0FEDCBA, 8'h00, 2, 3, 8'h96, 3};
    tbl[9]  = '{4'b1000, 1'b1, 25'h0000040, 8'h44, 0, 0, 8'h00, 3};
    tbl[10] = '{4'b0001, 1'b1, 25'h0000050, 8'h55, 0, 0, 8'h00, 0};

    rst = 1'b1; req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    mem_rdy = 1'b0; mem_val = 1'b0; mem_rdata = '0;
    repeat (3) tick;
    chk_all_zero("reset");
    rst = 1'b0;

    foreach (tbl[i]) txn(tbl[i]);

    // Spurious val in IDLE: sticky error, no response, data untouched.
    mem_val = 1'b1; mem_rdata = 8'hEE;
    tick;
    mem_val = 1'b0;
    chk("spur_perr", 32'(proto_err), 32'd1);
    chk("spur_no_rsp", 32'(rsp_valid), 32'd0);
    chk("spur_data_hold", 32'(rsp_data), 32'h96);
    repeat (3) tick;
    chk("spur_perr_sticky", 32'(proto_err), 32'd1);

    // Fairness: all ports writing continuously from reset.
    rst = 1'b1; req_valid = '1; req_wr = '1; mem_rdy = 1'b1;
    repeat (2) tick;
    chk("fair_rst_perr", 32'(proto_err), 32'd0);
    chk("fair_rst_data", 32'(rsp_data), 32'd0);
    for (int g = 0; g < 12; g++) exp_ack.push_back(g % NP);
    rst = 1'b0;
    cyc = 0;
    while (exp_ack.size() != 0 && cyc < 60) begin
      tick;
      cyc++;
    end
    req_valid = '0;
    chk("fair_grants_left", 32'(exp_ack.size()), 32'd0);
    exp_ack.delete();
    repeat (2) tick;
    mem_rdy = 1'b0;
    chk("fair_end_idle", 32'(busy), 32'd0);

    // Reset while a read is outstanding; the late val must not be routed.
    req_addr[2*AD +: AD] = 25'h0000055;
    req_wr = '0; req_valid = 4'b0100;
    exp_ack.push_back(2);
    tick;
    req_valid = '0; mem_rdy = 1'b1;
    tick;
    mem_rdy = 1'b0;
    chk("mid_busy_wait", 32'(busy), 32'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk_all_zero("mid_rst");
    mem_val = 1'b1; mem_rdata = 8'h77;
    tick;
    mem_val = 1'b0;
    chk("mid_no_rsp", 32'(rsp_valid), 32'd0);
    chk("mid_perr", 32'(proto_err), 32'd1);
    chk("mid_data", 32'(rsp_data), 32'd0);
    tick;
    chk("mid_no_rsp2", 32'(rsp_valid), 32'd0);

    chk("ack_q_empty", 32'(exp_ack.size()), 32'd0);
    chk("rsp_q_empty", 32'(exp_rsp.size()), 32'd0);
    if (exp_rsp.size() != 0) dummy = exp_rsp.pop_front();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
